sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO for the testbench and RTL buffering paths alongside the async FIFO. Provides depth, width, and programmable almost-full/almost-empty thresholds. It has two read modes: registered-output and first-word-fall-through (FWFT). It also provides an occupancy count, sticky overflow/underflow flags, and a synchronous flush. Its write/read port naming matches the async FIFO interfaces, so existing drivers and monitors attach with only the clock/reset changed.

---
 rtl/sync_fifo_param.sv | 118 +++++++++++
 tb/tb_sync_fifo_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock FIFO with occupancy count, almost-full/almost-empty
//   thresholds, sticky overflow/underflow and a synchronous flush.
//   Two read modes: registered rdata (FWFT=0) or first-word-fall-through
//   (FWFT=1).
// Ports
//   clk, rst_n       : clock (rising edge), async active-low reset
//   flush            : synchronous clear, beats winc/rinc in the same cycle
//   winc, wdata      : write request / data
//   wfull            : count == DEPTH
//   walmost_full     : count >= AFULL_THRESH
//   rinc, rdata      : read request / data
//   rempty           : count == 0
//   ralmost_empty    : count <= AEMPTY_THRESH
//   count            : occupancy 0..DEPTH
//   overflow         : sticky, write attempted while full
//   underflow        : sticky, read attempted while empty
module sync_fifo_param #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 8,
   parameter int AFULL_THRESH  = 2**ADDR_WIDTH-2,
   parameter int AEMPTY_THRESH = 2,
   parameter int FWFT          = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  winc,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  wfull,
   output logic                  walmost_full,
   input  logic                  rinc,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rempty,
   output logic                  ralmost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;   // MSB is the wrap bit
   logic [ADDR_WIDTH:0]   count_next;
   logic                  wr_ok, rd_ok;

   // Handshakes are qualified by the registered flags, so a full FIFO never
   // writes through and an empty one never reads through.
   assign wr_ok = winc & ~wfull;
   assign rd_ok = rinc & ~rempty;

   assign count_next = count + {{ADDR_WIDTH{1'b0}}, wr_ok}
                             - {{ADDR_WIDTH{1'b0}}, rd_ok};

   // Pointers, count and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         wfull         <= 1'b0;
         rempty        <= 1'b1;
         walmost_full  <= 1'b0;
         ralmost_empty <= 1'b1;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
      end else if (flush) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         wfull         <= 1'b0;
         rempty        <= 1'b1;
         walmost_full  <= 1'b0;
         ralmost_empty <= 1'b1;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         count         <= count_next;
         wfull         <= (count_next == DEPTH_C);
         rempty        <= (count_next == '0);
         walmost_full  <= (count_next >= AF_C);
         ralmost_empty <= (count_next <= AE_C);
         if (winc & wfull)  overflow  <= 1'b1;
         if (rinc & rempty) underflow <= 1'b1;
      end
   end

   // Storage is not reset; the rst_n term keeps a write from landing while
   // reset is held.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && wr_ok)
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= wdata;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented as soon as it is stored; rinc pops it.
         assign rdata = rempty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
      end else begin : g_reg
         // Loaded only on an accepted read; holds across rejected reads.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               rdata <= '0;
            else if (flush)
               rdata <= '0;
            else if (rd_ok)
               rdata <= mem[rd_ptr[ADDR_WIDTH-1:0]];
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one FWFT instance share
// the same stimulus and are compared every falling edge against a queue model.
module tb_sync_fifo_param;

   localparam int DW = 8;
   localparam int AW = 2;
   localparam int DEPTH = 4;
   localparam int AF = 3;
   localparam int AE = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0, winc = 1'b0, rinc = 1'b0;
   logic [DW-1:0] wdata = '0;

   logic          wfull0, wafull0, rempty0, raempty0, ov0, un0;
   logic [DW-1:0] rdata0;
   logic [AW:0]   count0;
   logic          wfull1, wafull1, rempty1, raempty1, ov1, un1;
   logic [DW-1:0] rdata1;
   logic [AW:0]   count1;

   always #5 clk = ~clk;

   sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
                     .AEMPTY_THRESH(AE), .FWFT(0)) d0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
      .wfull(wfull0), .walmost_full(wafull0), .rinc(rinc), .rdata(rdata0),
      .rempty(rempty0), .ralmost_empty(raempty0), .count(count0),
      .overflow(ov0), .underflow(un0));

   sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
                     .AEMPTY_THRESH(AE), .FWFT(1)) d1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
      .wfull(wfull1), .walmost_full(wafull1), .rinc(rinc), .rdata(rdata1),
      .rempty(rempty1), .ralmost_empty(raempty1), .count(count1),
      .overflow(ov1), .underflow(un1));

   // ---------------- model ----------------
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_rd = '0;
   bit            m_ov = 1'b0, m_un = 1'b0;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_rd = '0;
      m_ov = 1'b0;
      m_un = 1'b0;
   endtask

   task automatic model_step(input bit w, input logic [DW-1:0] wd, input bit r, input bit f);
      bit do_w, do_r;
      if (f) begin
         model_reset();
      end else begin
         do_w = w && (q.size() < DEPTH);
         do_r = r && (q.size() > 0);
         if (w && q.size() == DEPTH) m_ov = 1'b1;
         if (r && q.size() == 0)     m_un = 1'b1;
         if (do_r) m_rd = q.pop_front();
         if (do_w) q.push_back(wd);
      end
   endtask

   task automatic cmp_all();
      int n;
      logic [DW-1:0] head;
      n = q.size();
      head = (n > 0) ? q[0] : '0;
      chk("d0_count",  32'(count0),  32'(n));
      chk("d0_wfull",  32'(wfull0),  32'(n == DEPTH));
      chk("d0_rempty", 32'(rempty0), 32'(n == 0));
      chk("d0_afull",  32'(wafull0), 32'(n >= AF));
      chk("d0_aempty", 32'(raempty0),32'(n <= AE));
      chk("d0_ovf",    32'(ov0),     32'(m_ov));
      chk("d0_unf",    32'(un0),     32'(m_un));
      chk("d0_rdata",  32'(rdata0),  32'(m_rd));
      chk("d1_count",  32'(count1),  32'(n));
      chk("d1_wfull",  32'(wfull1),  32'(n == DEPTH));
      chk("d1_rempty", 32'(rempty1), 32'(n == 0));
      chk("d1_afull",  32'(wafull1), 32'(n >= AF));
      chk("d1_aempty", 32'(raempty1),32'(n <= AE));
      chk("d1_ovf",    32'(ov1),     32'(m_ov));
      chk("d1_unf",    32'(un1),     32'(m_un));
      chk("d1_rdata",  32'(rdata1),  32'(head));
   endtask

   // Per-cycle compare, away from the active edge
   always @(negedge clk) cmp_all();

   // One clock of stimulus; inputs return to idle 1 time unit after the edge
   task automatic cyc(input bit w, input logic [DW-1:0] wd, input bit r, input bit f);
      winc = w; wdata = wd; rinc = r; flush = f;
      @(posedge clk);
      if (rst_n) model_step(w, wd, r, f);
      #1;
      winc = 1'b0; rinc = 1'b0; flush = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"},  32'(count0),   32'd0);
      chk({tag, "_wfull"},  32'(wfull0),   32'd0);
      chk({tag, "_rempty"}, 32'(rempty0),  32'd1);
      chk({tag, "_afull"},  32'(wafull0),  32'd0);
      chk({tag, "_aempty"}, 32'(raempty0), 32'd1);
      chk({tag, "_ovf"},    32'(ov0),      32'd0);
      chk({tag, "_unf"},    32'(un0),      32'd0);
      chk({tag, "_rdata0"}, 32'(rdata0),   32'd0);
      chk({tag, "_rdata1"}, 32'(rdata1),   32'd0);
      chk({tag, "_count1"}, 32'(count1),   32'd0);
   endtask

   logic [DW-1:0] v;

   initial begin
      // ---- reset ----
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst_n = 1'b1;

      // ---- fill A1..A4, then overflow ----
      cyc(1, 8'hA1, 0, 0);
      chk("fill1_count", 32'(count0), 32'd1);
      chk("fill1_aempty", 32'(raempty0), 32'd1);
      cyc(1, 8'hA2, 0, 0);
      chk("fill2_count", 32'(count0), 32'd2);
      chk("fill2_aempty", 32'(raempty0), 32'd0);
      chk("fill2_afull", 32'(wafull0), 32'd0);
      cyc(1, 8'hA3, 0, 0);
      chk("fill3_count", 32'(count0), 32'd3);
      chk("fill3_afull", 32'(wafull0), 32'd1);
      chk("fill3_wfull", 32'(wfull0), 32'd0);
      cyc(1, 8'hA4, 0, 0);
      chk("fill4_count", 32'(count0), 32'd4);
      chk("fill4_wfull", 32'(wfull0), 32'd1);
      cyc(1, 8'hA5, 0, 0);
      chk("ovf_flag", 32'(ov0), 32'd1);
      chk("ovf_count", 32'(count0), 32'd4);

      // ---- drain, registered read ----
      chk("fwft_head_a1", 32'(rdata1), 32'hA1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 8'h00, 1, 0);
         v = 8'hA1 + 8'(i);
         chk("drain_rdata", 32'(rdata0), 32'(v));
      end
      chk("drain_rempty", 32'(rempty0), 32'd1);
      cyc(0, 8'h00, 1, 0);
      chk("unf_flag", 32'(un0), 32'd1);
      chk("unf_hold", 32'(rdata0), 32'hA4);
      cyc(0, 8'h00, 0, 1);
      chk("flush_ovf", 32'(ov0), 32'd0);
      chk("flush_rdata", 32'(rdata0), 32'd0);

      // ---- simultaneous access at count 2 ----
      cyc(1, 8'hB1, 0, 0);
      cyc(1, 8'hB2, 0, 0);
      cyc(1, 8'hB3, 1, 0);
      chk("sim2_count", 32'(count0), 32'd2);
      chk("sim2_rdata", 32'(rdata0), 32'hB1);
      cyc(0, 8'h00, 1, 0);
      chk("sim2_rd_b2", 32'(rdata0), 32'hB2);
      cyc(0, 8'h00, 1, 0);
      chk("sim2_rd_b3", 32'(rdata0), 32'hB3);

      // ---- simultaneous access at count 4 ----
      for (int i = 0; i < 4; i++) cyc(1, 8'hC1 + 8'(i), 0, 0);
      cyc(1, 8'hC5, 1, 0);
      chk("sim4_count", 32'(count0), 32'd3);
      chk("sim4_ovf", 32'(ov0), 32'd1);
      chk("sim4_rdata", 32'(rdata0), 32'hC1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 8'h00, 1, 0);
         v = 8'hC2 + 8'(i);
         chk("sim4_drain", 32'(rdata0), 32'(v));
      end
      chk("sim4_dropped", 32'(rempty0), 32'd1);
      cyc(0, 8'h00, 0, 1);

      // ---- wrap: 20 write/read pairs ----
      for (int i = 0; i < 20; i++) begin
         cyc(1, 8'(i), 0, 0);
         cyc(0, 8'h00, 1, 0);
         chk("wrap_rdata", 32'(rdata0), 32'(i));
      end
      chk("wrap_empty", 32'(rempty0), 32'd1);

      // ---- FWFT single word ----
      cyc(0, 8'h00, 0, 1);
      cyc(1, 8'h5C, 0, 0);
      chk("fwft_rdata", 32'(rdata1), 32'h5C);
      chk("fwft_rempty", 32'(rempty1), 32'd0);
      cyc(0, 8'h00, 0, 0);
      chk("fwft_hold", 32'(rdata1), 32'h5C);
      cyc(0, 8'h00, 1, 0);
      chk("fwft_pop_empty", 32'(rempty1), 32'd1);
      chk("fwft_pop_rdata", 32'(rdata1), 32'd0);

      // ---- flush beats winc at count 3 with overflow set ----
      for (int i = 0; i < 5; i++) cyc(1, 8'hD0 + 8'(i), 0, 0);
      cyc(0, 8'h00, 1, 0);
      chk("pre_flush_count", 32'(count0), 32'd3);
      chk("pre_flush_ovf", 32'(ov0), 32'd1);
      cyc(1, 8'hEE, 0, 1);
      chk("flushw_count", 32'(count0), 32'd0);
      chk("flushw_rempty", 32'(rempty0), 32'd1);
      chk("flushw_ovf", 32'(ov0), 32'd0);
      cyc(0, 8'h00, 0, 0);
      chk("flushw_dropped", 32'(count0), 32'd0);

      // ---- async reset mid-cycle at count 3 ----
      for (int i = 0; i < 3; i++) cyc(1, 8'hF0 + 8'(i), 0, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(1, 8'hF3, 0, 0);
      chk("prerst_count", 32'(count0), 32'd3);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_reset_vals("arst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(0, 8'h00, 0, 0);
      chk("post_rst_count", 32'(count0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
